match_selector: RTL and testbench

Streaming nearest-neighbour selector that consumes the per-candidate descriptor distances produced by the distance units. For each query descriptor it tracks the best and second-best distances over a candidate stream and records the best candidate index. At the end of the stream it applies a fixed-point ratio test and emits one match record per query over a valid/ready handshake. It sits between the distance-computation array and the match result buffer.

---
 rtl/match_selector.sv | 180 ++++++++++++++++++
 tb/tb_match_selector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_selector.sv
// match_selector
// Streaming nearest-neighbour selector. For each query it keeps the best and
// second-best candidate distances seen on the input stream, remembers the
// arrival index of the best one, and on the last candidate applies a
// fixed-point ratio test (best / second < RATIO_NUM / 2^RATIO_SHIFT).
// One match record per query is then presented over a valid/ready handshake.
//
// Flow: COLLECT (one candidate per cycle) -> DECIDE (one cycle, registers
// the ratio test and the record) -> OUTPUT (holds the record until accepted).
// in_ready is only high in COLLECT, so a candidate offered during DECIDE or
// OUTPUT simply waits on the input handshake.

module match_selector #(
    parameter int DIST_W      = 15,
    parameter int IDX_W       = 10,
    parameter int RATIO_NUM   = 13,
    parameter int RATIO_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_dist,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_best_idx,
    output logic [DIST_W-1:0] out_best_dist,
    output logic [DIST_W-1:0] out_second_dist,
    output logic [IDX_W-1:0]  out_count,
    output logic              out_match
);

    // Width of the ratio-test products: wide enough that neither
    // best << RATIO_SHIFT nor second * RATIO_NUM (RATIO_NUM <= 15) can overflow.
    localparam int CMP_W = DIST_W + RATIO_SHIFT + 4;

    // "No candidate yet" value for best and second.
    localparam logic [DIST_W-1:0] DIST_ONES = {DIST_W{1'b1}};
    localparam logic [IDX_W-1:0]  IDX_ZERO  = {IDX_W{1'b0}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DECIDE  = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // Ratio test: best / second < RATIO_NUM / 2^RATIO_SHIFT, cross-multiplied
    // so it stays in unsigned integer arithmetic.
    function automatic logic ratio_pass(
        input logic [DIST_W-1:0] best_d,
        input logic [DIST_W-1:0] second_d
    );
        logic [CMP_W-1:0] lhs;
        logic [CMP_W-1:0] rhs;
        lhs = CMP_W'(best_d) << RATIO_SHIFT;
        rhs = CMP_W'(second_d) * CMP_W'(RATIO_NUM);
        return (lhs < rhs);
    endfunction

    state_t            state_r;
    logic              collect_r;      // registered "state is COLLECT" flag
    logic [DIST_W-1:0] best_r;
    logic [DIST_W-1:0] second_r;
    logic [IDX_W-1:0]  best_idx_r;
    logic [IDX_W-1:0]  cnt_r;

    logic              out_valid_r;
    logic [IDX_W-1:0]  out_best_idx_r;
    logic [DIST_W-1:0] out_best_dist_r;
    logic [DIST_W-1:0] out_second_dist_r;
    logic [IDX_W-1:0]  out_count_r;
    logic              out_match_r;

    logic              in_ready_s;
    logic              xfer_s;
    logic [DIST_W-1:0] best_nx_s;
    logic [DIST_W-1:0] second_nx_s;
    logic [IDX_W-1:0]  best_idx_nx_s;

    // Accept candidates only in COLLECT, and never while reset is asserted so
    // nothing appears to be consumed in the reset cycle.
    assign in_ready_s = collect_r & ~rst;
    assign xfer_s     = in_valid & in_ready_s;

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign out_best_idx    = out_best_idx_r;
    assign out_best_dist   = out_best_dist_r;
    assign out_second_dist = out_second_dist_r;
    assign out_count       = out_count_r;
    assign out_match       = out_match_r;

    // Best/second update for the incoming candidate; strict compares keep the
    // earlier index on a tie and let the tied value fall through to second.
    always_comb begin
        best_nx_s     = best_r;
        second_nx_s   = second_r;
        best_idx_nx_s = best_idx_r;
        if (in_dist < best_r) begin
            second_nx_s   = best_r;
            best_nx_s     = in_dist;
            best_idx_nx_s = cnt_r;
        end else if (in_dist < second_r) begin
            second_nx_s   = in_dist;
        end else begin
            second_nx_s   = second_r;
        end
    end

    // Selector state machine: collection, decision and record hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= ST_COLLECT;
            collect_r         <= 1'b1;
            best_r            <= DIST_ONES;
            second_r          <= DIST_ONES;
            best_idx_r        <= IDX_ZERO;
            cnt_r             <= IDX_ZERO;
            out_valid_r       <= 1'b0;
            out_best_idx_r    <= IDX_ZERO;
            out_best_dist_r   <= DIST_ONES;
            out_second_dist_r <= DIST_ONES;
            out_count_r       <= IDX_ZERO;
            out_match_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (xfer_s) begin
                        best_r     <= best_nx_s;
                        second_r   <= second_nx_s;
                        best_idx_r <= best_idx_nx_s;
                        // Count wraps silently beyond 2^IDX_W candidates.
                        cnt_r      <= cnt_r + IDX_W'(1);
                        if (in_last) begin
                            state_r   <= ST_DECIDE;
                            collect_r <= 1'b0;
                        end
                    end
                end

                ST_DECIDE: begin
                    out_best_idx_r    <= best_idx_r;
                    out_best_dist_r   <= best_r;
                    out_second_dist_r <= second_r;
                    out_count_r       <= cnt_r;
                    out_match_r       <= ratio_pass(best_r, second_r);
                    out_valid_r       <= 1'b1;
                    state_r           <= ST_OUTPUT;
                end

                ST_OUTPUT: begin
                    // out_valid is always high here, so out_ready alone
                    // completes the handshake.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        best_r      <= DIST_ONES;
                        second_r    <= DIST_ONES;
                        best_idx_r  <= IDX_ZERO;
                        cnt_r       <= IDX_ZERO;
                        state_r     <= ST_COLLECT;
                        collect_r   <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to an empty COLLECT.
                    out_valid_r <= 1'b0;
                    best_r      <= DIST_ONES;
                    second_r    <= DIST_ONES;
                    best_idx_r  <= IDX_ZERO;
                    cnt_r       <= IDX_ZERO;
                    state_r     <= ST_COLLECT;
                    collect_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_selector.sv
// Self-checking bench for match_selector: directed cases plus randomized
// queries scored against a reference model that computes best/second from
// the whole query at once (minimum, first index of minimum, minimum of the
// rest).

module tb_match_selector;

    localparam int DIST_W      = 15;
    localparam int IDX_W       = 10;
    localparam int RATIO_NUM   = 13;
    localparam int RATIO_SHIFT = 4;
    localparam int ONES        = (1 << DIST_W) - 1;
    localparam int IDX_MOD     = 1 << IDX_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DIST_W-1:0] in_dist;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_best_idx;
    logic [DIST_W-1:0] out_best_dist;
    logic [DIST_W-1:0] out_second_dist;
    logic [IDX_W-1:0]  out_count;
    logic              out_match;

    int n_checks;
    int n_pass;

    match_selector #(
        .DIST_W(DIST_W), .IDX_W(IDX_W),
        .RATIO_NUM(RATIO_NUM), .RATIO_SHIFT(RATIO_SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dist(in_dist), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_best_idx(out_best_idx), .out_best_dist(out_best_dist),
        .out_second_dist(out_second_dist), .out_count(out_count),
        .out_match(out_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: whole-query view of the selection rules.
    task automatic model(input int q[$], output int b, output int s, output int bi,
                         output int cnt, output int m);
        longint lhs;
        longint rhs;
        b  = ONES;
        bi = 0;
        foreach (q[i]) if (q[i] < b) begin b = q[i]; bi = i; end
        s = ONES;
        foreach (q[i]) if (i != bi && q[i] < s) s = q[i];
        lhs = longint'(b) * (longint'(1) << RATIO_SHIFT);
        rhs = longint'(s) * longint'(RATIO_NUM);
        m   = (lhs < rhs) ? 1 : 0;
        bi  = bi % IDX_MOD;
        cnt = q.size() % IDX_MOD;
    endtask

    // Offer one candidate after 'gap' idle cycles; returns #1 after the
    // accepting edge (or, for a last candidate, one cycle later).
    task automatic send(input int d, input bit last, input int gap);
        int k;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_dist  = DIST_W'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_dist  = DIST_W'(d);
        in_last  = last;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_dist  = DIST_W'($urandom);
        in_last  = 1'($urandom);
        if (last) begin
            check("decide_out_valid", 32'(out_valid), 32'd0);
            check("decide_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check("out_valid_latency", 32'(out_valid), 32'd1);
        end
    endtask

    // Wait for a record, check it stays stable for 'hold' stalled cycles, then accept it.
    task automatic expect_record(input int eb, input int es, input int ei,
                                 input int ec, input int em, input int hold);
        int k;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        for (int h = 0; h <= hold; h++) begin
            check("best_dist", 32'(out_best_dist), 32'(eb));
            check("second_dist", 32'(out_second_dist), 32'(es));
            check("best_idx", 32'(out_best_idx), 32'(ei));
            check("count", 32'(out_count), 32'(ec));
            check("match", 32'(out_match), 32'(em));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_query(input int q[$], input int max_gap, input int hold);
        int b, s, bi, cnt, m;
        model(q, b, s, bi, cnt, m);
        foreach (q[i]) send(q[i], i == q.size() - 1, $urandom_range(0, max_gap));
        expect_record(b, s, bi, cnt, m, hold);
    endtask

    initial begin
        int q[$];
        int n;
        int r;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_match", 32'(out_match), 32'd0);
        check("rst_best_idx", 32'(out_best_idx), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_best_dist", 32'(out_best_dist), 32'(ONES));
        check("rst_second_dist", 32'(out_second_dist), 32'(ONES));
        rst = 1'b0;
        #1;
        check("after_rst_in_ready", 32'(in_ready), 32'd1);

        // Normal match: 640 < 1300
        send(300, 1'b0, 0); send(40, 1'b0, 0); send(100, 1'b1, 0);
        expect_record(40, 100, 1, 3, 1, 2);
        // Ratio reject: 800 >= 780
        send(100, 1'b0, 1); send(50, 1'b0, 0); send(200, 1'b0, 2); send(60, 1'b1, 0);
        expect_record(50, 60, 1, 4, 0, 0);
        // Tie keeps earlier index, tied value becomes second
        send(70, 1'b0, 0); send(70, 1'b1, 0);
        expect_record(70, 70, 0, 2, 0, 1);
        // Single candidate
        send(500, 1'b1, 0);
        expect_record(500, ONES, 0, 1, 1, 0);
        // Single all-ones candidate
        send(ONES, 1'b1, 0);
        expect_record(ONES, ONES, 0, 1, 0, 0);

        // Back-to-back: B waits on the input while A's record is stalled
        send(10, 1'b0, 0); send(20, 1'b1, 0);
        in_valid = 1'b1; in_dist = DIST_W'(5); in_last = 1'b1;
        expect_record(10, 20, 0, 2, 1, 5);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        expect_record(5, ONES, 0, 1, 1, 0);

        // Reset mid-query discards partial state
        send(30, 1'b0, 0); send(10, 1'b0, 0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("midrst_out_valid2", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        send(90, 1'b1, 0);
        expect_record(90, ONES, 0, 1, 1, 2);

        // Randomized queries against the model
        for (int t = 0; t < 60; t++) begin
            q.delete();
            n = $urandom_range(1, 10);
            r = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                if (r == 0)      q.push_back($urandom_range(0, 12));
                else if (r == 1) q.push_back($urandom_range(0, ONES));
                else             q.push_back(($urandom_range(0, 3) == 0) ? ONES : $urandom_range(1000, 1300));
            end
            run_query(q, 2, $urandom_range(0, 3));
        end

        // Long query: index and count wrap modulo 2^IDX_W
        q.delete();
        for (int i = 0; i < IDX_MOD + 6; i++) q.push_back($urandom_range(100, 32000));
        q[IDX_MOD + 3] = 7;
        run_query(q, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
